// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - control bus from the set-mode controller to the time/date counters
interface clock_set_ctrl_if;
    logic       source_en;
    logic       set_enable;
    logic [2:0] time_sel;
    logic       inc_pulse;
    logic       sync_load;
    logic       sec_clear;
    logic       blink;

    modport master (
        output source_en, set_enable, time_sel, inc_pulse, sync_load, sec_clear, blink
    );
    modport slave (
        input  source_en, set_enable, time_sel, inc_pulse, sync_load, sec_clear, blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - button-driven set-mode FSM, tick gating, sync and blink for the clock counters
// Optional: define AUTO_REPEAT_EN for btn_inc auto-repeat while held.
module clock_set_ctrl #(
    parameter int TIMEOUT_SEC   = 10,
    parameter int BLINK_HALF    = 25_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_cancel,
    input  logic             sync_req,
    clock_set_ctrl_if.master ctl
);
    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_MONTH = 3'd3,
        SET_YEAR  = 3'd4
    } state_t;

    localparam int TW = $clog2(TIMEOUT_SEC + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [BW-1:0] blink_cnt;
    logic          mode_prev, inc_prev, cancel_prev;
    logic          mode_edge, inc_edge, cancel_edge;
    logic          in_set, timeout_hit, changing;
    logic          clear_nxt, inc_nxt, rep_fire;

    assign mode_edge   = btn_mode   & ~mode_prev;
    assign inc_edge    = btn_inc    & ~inc_prev;
    assign cancel_edge = btn_cancel & ~cancel_prev;
    assign in_set      = (state != RUN);
    assign timeout_hit = in_set & tick & (timer == TIMER_LAST);
    assign changing    = (state_nxt != state);

    // Ticks are swallowed while setting so the edited value cannot roll underneath the user.
    assign ctl.source_en = tick & ~in_set;

    always_comb begin
        state_nxt = state;
        clear_nxt = 1'b0;
        inc_nxt   = 1'b0;
        if (sync_req) begin
            state_nxt = RUN;
        end else if (in_set && cancel_edge) begin
            state_nxt = RUN;
        end else if (timeout_hit) begin
            state_nxt = RUN;
        end else if (mode_edge) begin
            case (state)
                RUN:       state_nxt = SET_HOUR;
                SET_HOUR:  state_nxt = SET_MIN;
                SET_MIN:   state_nxt = SET_MONTH;
                SET_MONTH: state_nxt = SET_YEAR;
                SET_YEAR: begin
                    state_nxt = RUN;
                    clear_nxt = 1'b1;
                end
                default:   state_nxt = RUN;
            endcase
        end else if (in_set && (inc_edge || rep_fire)) begin
            inc_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            ctl.time_sel   <= 3'd0;
            ctl.set_enable <= 1'b0;
            ctl.inc_pulse  <= 1'b0;
            ctl.sync_load  <= 1'b0;
            ctl.sec_clear  <= 1'b0;
            ctl.blink      <= 1'b1;
            timer          <= '0;
            blink_cnt      <= '0;
            mode_prev      <= 1'b1;
            inc_prev       <= 1'b1;
            cancel_prev    <= 1'b1;
        end else begin
            mode_prev      <= btn_mode;
            inc_prev       <= btn_inc;
            cancel_prev    <= btn_cancel;
            state          <= state_nxt;
            ctl.time_sel   <= state_nxt;
            ctl.set_enable <= (state_nxt != RUN);
            ctl.inc_pulse  <= inc_nxt;
            ctl.sync_load  <= sync_req;
            ctl.sec_clear  <= clear_nxt;

            if (sync_req || changing || !in_set || mode_edge || inc_edge || cancel_edge || rep_fire)
                timer <= '0;
            else if (tick)
                timer <= timer + 1'b1;

            // Any increment restarts the blink phase lit, so the new value is seen at once.
            if (state_nxt == RUN || changing || inc_nxt) begin
                ctl.blink <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                ctl.blink <= ~ctl.blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          rep_on;
    logic          rep_first;
    logic [RW-1:0] rep_cnt;

    assign rep_fire = rep_on & btn_inc & (rep_cnt == (rep_first ? DELAY_LAST : PERIOD_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_on    <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else if (changing || !btn_inc || !in_set) begin
            rep_on    <= 1'b0;
            rep_cnt   <= '0;
        end else if (inc_nxt) begin
            rep_on    <= 1'b1;
            rep_first <= inc_edge;
            rep_cnt   <= '0;
        end else if (rep_on) begin
            rep_cnt   <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;
    localparam int TIMEOUT_SEC   = 10;
    localparam int BLINK_HALF    = 8;
    localparam int REPEAT_DELAY  = 20;
    localparam int REPEAT_PERIOD = 5;
    localparam int HOLD          = 40;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;
    logic btn_cancel = 1'b0;
    logic sync_req = 1'b0;

    int   nvec = 0;
    int   nerr = 0;
    int   src_cnt = 0;
    int   inc_cnt = 0;
    int   exp_rep;
    logic clear_seen = 1'b0;
    int   exp_sel [5] = '{1, 2, 3, 4, 0};

    clock_set_ctrl_if ctl ();

    clock_set_ctrl #(
        .TIMEOUT_SEC  (TIMEOUT_SEC),
        .BLINK_HALF   (BLINK_HALF),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_cancel(btn_cancel),
        .sync_req  (sync_req),
        .ctl       (ctl.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ctl.sec_clear) clear_seen = 1'b1;
            if (ctl.inc_pulse) inc_cnt++;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        #1;
        if (ctl.source_en) src_cnt++;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cyc(1);
        btn_mode = 1'b0;
        cyc(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        btn_mode = 1'b1;
        cyc(3);
        chk("rst_time_sel", ctl.time_sel, 0);
        chk("rst_set_enable", ctl.set_enable, 0);
        chk("rst_blink", ctl.blink, 1);
        chk("rst_pulses", {ctl.inc_pulse, ctl.sync_load, ctl.sec_clear}, 0);

        reset = 1'b1;
        cyc(4);
        chk("held_mode_time_sel", ctl.time_sel, 0);
        chk("held_mode_set_enable", ctl.set_enable, 0);
        btn_mode = 1'b0;
        cyc(1);

        src_cnt = 0;
        repeat (3) pulse_tick();
        chk("run_source_en_count", src_cnt, 3);

        btn_mode = 1'b1;
        cyc(1);
        chk("enter_hour_time_sel", ctl.time_sel, 1);
        chk("enter_hour_set_enable", ctl.set_enable, 1);
        chk("enter_hour_blink", ctl.blink, 1);
        btn_mode = 1'b0;
        cyc(7);
        chk("blink_before_toggle", ctl.blink, 1);
        cyc(1);
        chk("blink_after_toggle", ctl.blink, 0);

        inc_cnt = 0;
        btn_inc = 1'b1;
        cyc(1);
        chk("inc_pulse_first", ctl.inc_pulse, 1);
        chk("inc_pulse_time_sel", ctl.time_sel, 1);
        chk("inc_forces_blink", ctl.blink, 1);
        cyc(5);
        btn_inc = 1'b0;
        cyc(2);
        chk("inc_pulse_count", inc_cnt, 1);

        src_cnt = 0;
        repeat (3) pulse_tick();
        chk("set_source_en_count", src_cnt, 0);
        chk("set_ticks_time_sel", ctl.time_sel, 1);

        btn_cancel = 1'b1;
        cyc(1);
        chk("cancel_time_sel", ctl.time_sel, 0);
        chk("cancel_sec_clear", ctl.sec_clear, 0);
        btn_cancel = 1'b0;
        cyc(1);

        for (int i = 0; i < 5; i++) begin
            btn_mode = 1'b1;
            cyc(1);
            chk($sformatf("mode_seq_%0d_time_sel", i), ctl.time_sel, exp_sel[i]);
            chk($sformatf("mode_seq_%0d_sec_clear", i), ctl.sec_clear, (i == 4) ? 1 : 0);
            btn_mode = 1'b0;
            cyc(1);
            chk($sformatf("mode_seq_%0d_clear_low", i), ctl.sec_clear, 0);
        end

        clear_seen = 1'b0;
        press_mode();
        press_mode();
        chk("to_min_time_sel", ctl.time_sel, 2);
        repeat (9) pulse_tick();
        chk("timeout_tick9", ctl.time_sel, 2);
        pulse_tick();
        chk("timeout_tick10", ctl.time_sel, 0);
        chk("timeout_no_clear", clear_seen, 0);

        press_mode();
        press_mode();
        repeat (6) pulse_tick();
        btn_inc = 1'b1;
        cyc(1);
        btn_inc = 1'b0;
        cyc(1);
        repeat (9) pulse_tick();
        chk("timeout_rearm_tick15", ctl.time_sel, 2);
        pulse_tick();
        chk("timeout_rearm_tick16", ctl.time_sel, 0);

        press_mode();
        press_mode();
        press_mode();
        chk("to_month_time_sel", ctl.time_sel, 3);
        sync_req = 1'b1;
        btn_mode = 1'b1;
        cyc(1);
        chk("sync_load_pulse", ctl.sync_load, 1);
        chk("sync_time_sel", ctl.time_sel, 0);
        chk("sync_set_enable", ctl.set_enable, 0);
        sync_req = 1'b0;
        btn_mode = 1'b0;
        cyc(1);
        chk("sync_load_single", ctl.sync_load, 0);
        chk("sync_no_advance", ctl.time_sel, 0);

        press_mode();
        chk("repeat_hour_time_sel", ctl.time_sel, 1);
`ifdef AUTO_REPEAT_EN
        exp_rep = 1 + (((HOLD - 1) >= REPEAT_DELAY) ? 1 + (HOLD - 1 - REPEAT_DELAY) / REPEAT_PERIOD : 0);
`else
        exp_rep = 1;
`endif
        inc_cnt = 0;
        btn_inc = 1'b1;
        cyc(HOLD);
        btn_inc = 1'b0;
        cyc(3);
        chk("hold_inc_pulse_count", inc_cnt, exp_rep);

        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_time_sel", ctl.time_sel, 0);
        chk("async_rst_set_enable", ctl.set_enable, 0);
        chk("async_rst_blink", ctl.blink, 1);
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        chk("post_rst_time_sel", ctl.time_sel, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
